mor1kx_rf_scoreboard_marocchino: RTL

//  Register file for the MAROCCHINO pipeline. It sits downstream of the write-back mux and consumes wb_rf_wb/wb_rfd_adr/wb_result.
//  It supplies registered A/B operands to EXEC, with same-cycle write-back bypass.
//  A per-register busy scoreboard flags RAW/WAW hazards for decode, so control can stall padv_exec.

---
 rtl/mor1kx_rf_scoreboard_marocchino_pkg.sv | 22 ++
 rtl/mor1kx_rf_scoreboard_marocchino_if.sv | 38 +++
 rtl/mor1kx_rf_bypass_marocchino.sv | 28 ++
 rtl/mor1kx_rf_scoreboard_marocchino.sv | 109 ++++++++++
 4 files changed

// File: rtl/mor1kx_rf_scoreboard_marocchino_pkg.sv
// Shared constants and types for the MAROCCHINO register file and busy scoreboard.
// MOR1KX_RF_R0_HARDWIRE_EN: r0 reads zero, ignores writes and is never scoreboarded.
package mor1kx_rf_scoreboard_marocchino_pkg;

   localparam int RF_OPERAND_WIDTH = 32;
   localparam int RF_ADDR_WIDTH    = 5;

   function automatic int num_regs(input int addr_width);
      return 1 << addr_width;
   endfunction

   localparam int RF_NUM_REGS = num_regs(RF_ADDR_WIDTH);

   typedef logic [RF_ADDR_WIDTH-1:0] gpr_adr_t;

`ifdef MOR1KX_RF_R0_HARDWIRE_EN
   localparam bit R0_HARDWIRE = 1'b1;
`else
   localparam bit R0_HARDWIRE = 1'b0;
`endif

endpackage

// File: rtl/mor1kx_rf_scoreboard_marocchino_if.sv
// Decode/exec/write-back bundle between pipeline control and the register file.
interface mor1kx_rf_scoreboard_marocchino_if #(
   parameter int OW = 32,
   parameter int AW = 5
);
   // Handshake: an insn moves DECODE->EXEC on the edge where padv_exec_i=1;
   // dcod_hazard_o=1 means "not ready" and control must hold padv_exec_i low.
   logic          padv_exec_i;
   logic          pipeline_flush_i;
   logic          dcod_rfa_req_i;
   logic [AW-1:0] dcod_rfa_adr_i;
   logic          dcod_rfb_req_i;
   logic [AW-1:0] dcod_rfb_adr_i;
   logic          dcod_rf_wb_i;
   logic [AW-1:0] dcod_rfd_adr_i;
   logic          dcod_hazard_o;
   logic [OW-1:0] exec_rfa_o;
   logic [OW-1:0] exec_rfb_o;
   logic          wb_rf_wb_i;
   logic [AW-1:0] wb_rfd_adr_i;
   logic [OW-1:0] wb_result_i;

   modport master (
      output padv_exec_i, pipeline_flush_i,
      output dcod_rfa_req_i, dcod_rfa_adr_i, dcod_rfb_req_i, dcod_rfb_adr_i,
      output dcod_rf_wb_i, dcod_rfd_adr_i,
      output wb_rf_wb_i, wb_rfd_adr_i, wb_result_i,
      input  dcod_hazard_o, exec_rfa_o, exec_rfb_o
   );

   modport slave (
      input  padv_exec_i, pipeline_flush_i,
      input  dcod_rfa_req_i, dcod_rfa_adr_i, dcod_rfb_req_i, dcod_rfb_adr_i,
      input  dcod_rf_wb_i, dcod_rfd_adr_i,
      input  wb_rf_wb_i, wb_rfd_adr_i, wb_result_i,
      output dcod_hazard_o, exec_rfa_o, exec_rfb_o
   );
endinterface

// File: rtl/mor1kx_rf_bypass_marocchino.sv
// One read port: selects same-cycle write-back data over the stored GPR value.
// Honours MOR1KX_RF_R0_HARDWIRE_EN through the package's R0_HARDWIRE flag.
module mor1kx_rf_bypass_marocchino
   import mor1kx_rf_scoreboard_marocchino_pkg::*;
#(
   parameter int OW = 32,
   parameter int AW = 5
) (
   input  logic [AW-1:0] rd_adr_i,
   input  logic [OW-1:0] gpr_data_i,
   input  logic          wb_rf_wb_i,
   input  logic [AW-1:0] wb_rfd_adr_i,
   input  logic [OW-1:0] wb_result_i,
   output logic [OW-1:0] rd_data_o
);

   logic wb_hit;
   assign wb_hit = wb_rf_wb_i & (wb_rfd_adr_i == rd_adr_i);

   always_comb begin
      rd_data_o = gpr_data_i;
      if (wb_hit)
         rd_data_o = wb_result_i;
      if (R0_HARDWIRE && (rd_adr_i == '0))
         rd_data_o = '0;
   end

endmodule

// File: rtl/mor1kx_rf_scoreboard_marocchino.sv
// MAROCCHINO GPR file: flop array, registered EXEC operands with WB bypass, busy scoreboard.
// MOR1KX_RF_R0_HARDWIRE_EN (package) makes r0 a constant zero that is never busy.
module mor1kx_rf_scoreboard_marocchino
   import mor1kx_rf_scoreboard_marocchino_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = RF_OPERAND_WIDTH,
   parameter int OPTION_RF_ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mor1kx_rf_scoreboard_marocchino_if.slave rf_s,
   output logic [num_regs(OPTION_RF_ADDR_WIDTH)-1:0] busy_vec_o
);

   localparam int OW       = OPTION_OPERAND_WIDTH;
   localparam int AW       = OPTION_RF_ADDR_WIDTH;
   localparam int NUM_REGS = num_regs(AW);

   logic [OW-1:0]       gpr_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [OW-1:0]       exec_rfa_q, exec_rfa_d;
   logic [OW-1:0]       exec_rfb_q, exec_rfb_d;
   logic                gpr_we;
   logic                capture;
   logic [OW-1:0]       rfa_byp, rfb_byp;
   logic                eff_busy_a, eff_busy_b, eff_busy_d;

   assign gpr_we  = rf_s.wb_rf_wb_i & ~(R0_HARDWIRE && (rf_s.wb_rfd_adr_i == '0));
   assign capture = rf_s.padv_exec_i & ~rf_s.pipeline_flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            gpr_q[i] <= '0;
      end else if (gpr_we) begin
         gpr_q[rf_s.wb_rfd_adr_i] <= rf_s.wb_result_i;
      end
   end

   mor1kx_rf_bypass_marocchino #(.OW(OW), .AW(AW)) u_byp_a (
      .rd_adr_i     (rf_s.dcod_rfa_adr_i),
      .gpr_data_i   (gpr_q[rf_s.dcod_rfa_adr_i]),
      .wb_rf_wb_i   (rf_s.wb_rf_wb_i),
      .wb_rfd_adr_i (rf_s.wb_rfd_adr_i),
      .wb_result_i  (rf_s.wb_result_i),
      .rd_data_o    (rfa_byp)
   );

   mor1kx_rf_bypass_marocchino #(.OW(OW), .AW(AW)) u_byp_b (
      .rd_adr_i     (rf_s.dcod_rfb_adr_i),
      .gpr_data_i   (gpr_q[rf_s.dcod_rfb_adr_i]),
      .wb_rf_wb_i   (rf_s.wb_rf_wb_i),
      .wb_rfd_adr_i (rf_s.wb_rfd_adr_i),
      .wb_result_i  (rf_s.wb_result_i),
      .rd_data_o    (rfb_byp)
   );

   always_comb begin
      exec_rfa_d = exec_rfa_q;
      exec_rfb_d = exec_rfb_q;
      if (capture) begin
         exec_rfa_d = rfa_byp;
         exec_rfb_d = rfb_byp;
      end
   end

   // Flush beats everything; a new producer beats a retiring one on the same register.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rf_s.pipeline_flush_i)
            busy_d[i] = 1'b0;
         else if (rf_s.padv_exec_i & rf_s.dcod_rf_wb_i & (rf_s.dcod_rfd_adr_i == AW'(i)) &
                  ~(R0_HARDWIRE && (i == 0)))
            busy_d[i] = 1'b1;
         else if (rf_s.wb_rf_wb_i & (rf_s.wb_rfd_adr_i == AW'(i)))
            busy_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         exec_rfa_q <= '0;
         exec_rfb_q <= '0;
      end else begin
         busy_q     <= busy_d;
         exec_rfa_q <= exec_rfa_d;
         exec_rfb_q <= exec_rfb_d;
      end
   end

   // A register whose producer is writing back this cycle is readable via bypass.
   assign eff_busy_a = busy_q[rf_s.dcod_rfa_adr_i] &
                       ~(rf_s.wb_rf_wb_i & (rf_s.wb_rfd_adr_i == rf_s.dcod_rfa_adr_i));
   assign eff_busy_b = busy_q[rf_s.dcod_rfb_adr_i] &
                       ~(rf_s.wb_rf_wb_i & (rf_s.wb_rfd_adr_i == rf_s.dcod_rfb_adr_i));
   assign eff_busy_d = busy_q[rf_s.dcod_rfd_adr_i] &
                       ~(rf_s.wb_rf_wb_i & (rf_s.wb_rfd_adr_i == rf_s.dcod_rfd_adr_i));

   assign rf_s.dcod_hazard_o = (rf_s.dcod_rfa_req_i & eff_busy_a) |
                               (rf_s.dcod_rfb_req_i & eff_busy_b) |
                               (rf_s.dcod_rf_wb_i   & eff_busy_d);

   assign rf_s.exec_rfa_o = exec_rfa_q;
   assign rf_s.exec_rfb_o = exec_rfb_q;
   assign busy_vec_o      = busy_q;

endmodule
